m_decimator: RTL

//  Multi-channel ADC decimator: reduces CHANNELS streams of DW-bit samples by 2^k
//  per window in sample, peak (min/max) or average mode. Sits between the ADC

---
 rtl/m_decimator_pkg.sv | 23 ++
 rtl/m_decim_lane.sv | 82 ++++++++
 rtl/m_decimator.sv | 107 ++++++++++
 3 files changed

// File: rtl/m_decimator_pkg.sv
// Shared constants for the multi-channel ADC decimator: mode encodings,
// register offsets and the window-length helper.
package m_decimator_pkg;

  localparam int CNT_W = 15;

  localparam logic [1:0] MODE_SAMPLE = 2'd0;
  localparam logic [1:0] MODE_PEAK   = 2'd1;
  localparam logic [1:0] MODE_AVG    = 2'd2;

  localparam int REG_MODE   = 0;
  localparam int REG_RATIO  = 1;
  localparam int REG_MASK   = 2;
  localparam int REG_STATUS = 3;

  // Last counter value of a window of 2^k strobes.
  function automatic logic [CNT_W-1:0] window_last(input logic [3:0] k);
    logic [CNT_W:0] span;
    span = (CNT_W+1)'(1) << k;
    return CNT_W'(span - (CNT_W+1)'(1));
  endfunction

endpackage

// File: rtl/m_decim_lane.sv
// One decimator channel: first/min/max/sum accumulators and the result mux,
// with the window result registered on the closing strobe.
module m_decim_lane
  import m_decimator_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          sample_valid,
  input  logic          win_open,
  input  logic          win_close,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic [3:0]    k,
  input  logic [DW-1:0] sample,
  output logic [DW-1:0] out_max,
  output logic [DW-1:0] out_min
);

  localparam int SW = DW + CNT_W;

  logic [DW-1:0] first_reg, min_reg, max_reg;
  logic [SW-1:0] sum_reg;
  logic [DW-1:0] first_next, min_next, max_next;
  logic [SW-1:0] sum_next, avg_full;
  logic [DW-1:0] res_max, res_min;

  // The *_next values already include the current sample, so the closing
  // strobe contributes to the result it produces.
  always_comb begin
    first_next = win_open ? sample : first_reg;
    min_next   = (win_open || sample < min_reg) ? sample : min_reg;
    max_next   = (win_open || sample > max_reg) ? sample : max_reg;
    sum_next   = win_open ? SW'(sample) : sum_reg + SW'(sample);
    avg_full   = sum_next >> k;
  end

  always_comb begin
    res_max = first_next;
    res_min = first_next;
    case (mode)
      MODE_PEAK: begin
        res_max = max_next;
        res_min = min_next;
      end
      MODE_AVG: begin
        res_max = avg_full[DW-1:0];
        res_min = avg_full[DW-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      first_reg <= '0;
      min_reg   <= '0;
      max_reg   <= '0;
      sum_reg   <= '0;
      out_max   <= '0;
      out_min   <= '0;
    end else begin
      if (!enable) begin
        first_reg <= '0;
        min_reg   <= '0;
        max_reg   <= '0;
        sum_reg   <= '0;
      end else if (sample_valid) begin
        first_reg <= first_next;
        min_reg   <= min_next;
        max_reg   <= max_next;
        sum_reg   <= sum_next;
      end
      if (win_close) begin
        out_max <= enable ? res_max : '0;
        out_min <= enable ? res_min : '0;
      end
    end
  end

endmodule

// File: rtl/m_decimator.sv
// Multi-channel ADC decimator: PicoBlaze register bank with shadowed config,
// window counter, and one m_decim_lane per channel.
module m_decimator
  import m_decimator_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DW       = 8,
  parameter int BASE     = 16
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [7:0]             port_id,
  input  logic [7:0]             out_port,
  input  logic                   write_strobe,
  output logic [7:0]             in_port,
  input  logic                   sample_valid,
  input  logic [CHANNELS*DW-1:0] data_in,
  output logic [CHANNELS*DW-1:0] data_out_max,
  output logic [CHANNELS*DW-1:0] data_out_min,
  output logic                   out_valid
);

  localparam logic [7:0] ADDR_MODE   = 8'(BASE + REG_MODE);
  localparam logic [7:0] ADDR_RATIO  = 8'(BASE + REG_RATIO);
  localparam logic [7:0] ADDR_MASK   = 8'(BASE + REG_MASK);
  localparam logic [7:0] ADDR_STATUS = 8'(BASE + REG_STATUS);

  logic [1:0]          mode_reg, mode_shadow_reg, eff_mode;
  logic [3:0]          k_reg, k_shadow_reg, eff_k;
  logic [CHANNELS-1:0] mask_reg, mask_shadow_reg, eff_mask;
  logic                cfg_pending_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                out_valid_reg;

  logic wr_mode, wr_ratio, wr_mask, any_wr;
  logic window_idle, load, win_open, win_close;

  always_comb begin
    wr_mode  = write_strobe && (port_id == ADDR_MODE);
    wr_ratio = write_strobe && (port_id == ADDR_RATIO);
    wr_mask  = write_strobe && (port_id == ADDR_MASK);
    any_wr   = wr_mode || wr_ratio || wr_mask;
  end

  // With no window open the shadow values govern the opening strobe directly,
  // so a pending config takes effect even when strobes arrive every cycle.
  always_comb begin
    window_idle = (cnt_reg == '0);
    load        = window_idle && cfg_pending_reg;
    eff_mode    = window_idle ? mode_shadow_reg : mode_reg;
    eff_k       = window_idle ? k_shadow_reg    : k_reg;
    eff_mask    = window_idle ? mask_shadow_reg : mask_reg;
    win_open    = sample_valid && window_idle;
    win_close   = sample_valid && (cnt_reg == window_last(eff_k));
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      mode_reg        <= MODE_SAMPLE;
      mode_shadow_reg <= MODE_SAMPLE;
      k_reg           <= '0;
      k_shadow_reg    <= '0;
      mask_reg        <= '1;
      mask_shadow_reg <= '1;
      cfg_pending_reg <= 1'b0;
      cnt_reg         <= '0;
      out_valid_reg   <= 1'b0;
    end else begin
      if (load) begin
        mode_reg <= mode_shadow_reg;
        k_reg    <= k_shadow_reg;
        mask_reg <= mask_shadow_reg;
      end
      if (wr_mode)  mode_shadow_reg <= out_port[1:0];
      if (wr_ratio) k_shadow_reg    <= out_port[3:0];
      if (wr_mask)  mask_shadow_reg <= out_port[CHANNELS-1:0];
      // A write coinciding with a load is newer than what was loaded.
      if (any_wr)
        cfg_pending_reg <= 1'b1;
      else if (load)
        cfg_pending_reg <= 1'b0;
      if (sample_valid)
        cnt_reg <= win_close ? '0 : cnt_reg + CNT_W'(1);
      out_valid_reg <= win_close;
    end
  end

  assign out_valid = out_valid_reg;
  assign in_port   = (port_id == ADDR_STATUS) ? {6'b0, |mask_reg, cfg_pending_reg} : 8'h00;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    m_decim_lane #(.DW(DW)) u_lane (
      .CLK          (CLK),
      .reset        (reset),
      .sample_valid (sample_valid),
      .win_open     (win_open),
      .win_close    (win_close),
      .enable       (eff_mask[gi]),
      .mode         (eff_mode),
      .k            (eff_k),
      .sample       (data_in[gi*DW +: DW]),
      .out_max      (data_out_max[gi*DW +: DW]),
      .out_min      (data_out_min[gi*DW +: DW])
    );
  end

endmodule
